// File: rtl/pixel_stacker_if.sv
// pixel_stacker_if: AXI-Stream style valid/ready bus with data and last.
// Parameter W sets the tdata width.
// Modports:
//   master  drives tvalid, tdata and tlast; receives tready.
//   slave   receives tvalid, tdata and tlast; drives tready.
interface pixel_stacker_if #(
    parameter int W = 16
);
    logic         tvalid;
    logic         tready;
    logic         tlast;
    logic [W-1:0] tdata;
    modport master(output tvalid, tdata, tlast, input tready);
    modport slave(input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/pixel_stacker.sv
// pixel_stacker: packs 16-bit pixels eight at a time into 128-bit words for the DRAM crossing FIFO.
// Ports:
//   sender_clk, sender_rstn  clock; synchronous active-low reset
//   pixel (slave)            16-bit pixel stream in; pixel 0 of a word lands in the LSBs
//   chunk (master)           128-bit packed word stream out, driven straight from the output register
//   chunk_prog_full          FIFO almost-full; stalls the pixel input only, never the output
//   misaligned_last          sticky: tlast accepted in a slot other than the last
//   words_sent               count of output handshakes, wrapping
// Build option PIXEL_STACKER_FLUSH_EN: a mid-word tlast closes the word at once, zero-padded.
module pixel_stacker #(
    parameter int PIXEL_WIDTH = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   sender_clk,
    input  logic                   sender_rstn,
    pixel_stacker_if.slave         pixel,
    pixel_stacker_if.master        chunk,
    input  logic                   chunk_prog_full,
    output logic                   misaligned_last,
    output logic [COUNT_WIDTH-1:0] words_sent
);
    localparam int SLOTS = 128 / PIXEL_WIDTH;
    localparam logic [2:0] LAST_SLOT = 3'(SLOTS - 1);
    logic [2:0]             slot_q, slot_d;
    logic [127:0]           acc_q, acc_d, out_data_q, out_data_d, word;
    logic                   acc_last_q, acc_last_d;
    logic                   out_last_q, out_last_d;
    logic                   out_valid_q, out_valid_d;
    logic                   mis_q, mis_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   closing, accept, load, drain;
`ifdef PIXEL_STACKER_FLUSH_EN
    assign closing = slot_q == LAST_SLOT || pixel.tlast;
`else
    assign closing = slot_q == LAST_SLOT;
`endif
    // A closing pixel may only enter when the output register is free or draining this edge.
    assign pixel.tready = sender_rstn && !chunk_prog_full && !(closing && out_valid_q && !chunk.tready);
    assign accept = pixel.tvalid && pixel.tready;
    assign load = accept && closing;
    assign drain = out_valid_q && chunk.tready;
    // Slots at and above the write pointer are always zero (the accumulator clears on every close),
    // so OR-ing the pixel in both completes a full word and zero-pads an early flush.
    assign word = acc_q | (128'(pixel.tdata) << (int'(slot_q) * PIXEL_WIDTH));
    always_comb begin
        slot_d = accept ? (closing ? 3'd0 : slot_q + 3'd1) : slot_q;
        acc_d = accept ? (closing ? '0 : word) : acc_q;
        acc_last_d = accept ? (!closing && (acc_last_q || pixel.tlast)) : acc_last_q;
        out_valid_d = load || (out_valid_q && !chunk.tready);
        out_data_d = load ? word : out_data_q;
        out_last_d = load ? (acc_last_q || pixel.tlast) : out_last_q;
        mis_d = mis_q || (accept && pixel.tlast && slot_q != LAST_SLOT);
        cnt_d = cnt_q + COUNT_WIDTH'(drain);
    end
    always_ff @(posedge sender_clk) begin
        if (!sender_rstn) begin
            slot_q <= '0;
            acc_q <= '0;
            acc_last_q <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            out_valid_q <= 1'b0;
            mis_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            slot_q <= slot_d;
            acc_q <= acc_d;
            acc_last_q <= acc_last_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            out_valid_q <= out_valid_d;
            mis_q <= mis_d;
            cnt_q <= cnt_d;
        end
    end
    assign chunk.tvalid = out_valid_q;
    assign chunk.tdata = out_data_q;
    assign chunk.tlast = out_last_q;
    assign misaligned_last = mis_q;
    assign words_sent = cnt_q;
endmodule

// File: doc/pixel_stacker.md
# pixel_stacker

Packs a 16-bit pixel AXI-Stream into 128-bit words (8 pixels each) and presents them on an AXI-Stream master. The master feeds the sender side of the DRAM clock-domain crossing FIFO. The block throttles its pixel input from that FIFO's `prog_full` flag, so bursts never overrun the crossing. It runs entirely in the sender (pixel) clock domain.

## Interface
- `PIXEL_WIDTH`, 16: bits per pixel; 128 / `PIXEL_WIDTH` = `SLOTS` = 8, fixed.
- `COUNT_WIDTH`, 16: width of the `words_sent` counter.

Ports:
- `sender_clk`  in  1  pixel/sender clock; all logic on its rising edge.
- `sender_rstn`  in  1  reset, synchronous, active-low.
- `pixel_tvalid`  in  1  input pixel valid.
- `pixel_tready`  out  1  input pixel ready.
- `pixel_tdata`  in  16  pixel value.
- `pixel_tlast`  in  1  last pixel of frame.
- `chunk_tvalid`  out  1  packed word valid (to FIFO `sender_axis_tvalid`).
- `chunk_tready`  in  1  from FIFO `sender_axis_tready`.
- `chunk_tdata`  out  128  packed word.
- `chunk_tlast`  out  1  word holds last pixel of frame.
- `chunk_prog_full`  in  1  FIFO `sender_axis_prog_full`.
- `misaligned_last`  out  1  sticky: `pixel_tlast` seen with slot ≠ 7.
- `words_sent`  out  `COUNT_WIDTH`  count of completed output handshakes; wraps modulo 2^`COUNT_WIDTH`.

## Operation
Storage:
- Accumulator: `acc_data[127:0]`, `slot[2:0]`, and `acc_last`.
- Output register: `out_data`, `out_last`, `out_valid`. `chunk_*` are driven directly from the output register.

Packing:
- The pixel accepted in slot k is written to `acc_data[16k +: 16]`. Pixel 0 goes in the LSBs.
- Accept means `pixel_tvalid && pixel_tready`.
- On accept with `slot < 7`:
  - `slot` increments.
  - `acc_last` ORs in `pixel_tlast`.
- On accept with `slot == 7`, the completed word (including the current pixel) moves to the output register:
  - `out_valid` ← 1.
  - `out_last` ← `acc_last | pixel_tlast`.
  - `slot` ← 0 and `acc_last` ← 0.

Ready rule (combinational):
- `pixel_tready = !chunk_prog_full && !(slot == 7 && out_valid && !chunk_tready)`.
- A completed word enters the output register in the same cycle the previous word drains.

Output handshake:
- When `chunk_tvalid && chunk_tready`:
  - `out_valid` clears, unless a new word loads that same edge.
  - `words_sent` increments.
- `chunk_tdata` and `chunk_tlast` stay stable while `chunk_tvalid && !chunk_tready`.

Error flag:
- `misaligned_last` sets on any accept with `pixel_tlast == 1` and `slot != 7`.
- It clears only on reset.

States: EMPTY (`slot == 0`, `!out_valid`), FILLING (`slot > 0`), STALLED (`slot == 7`, `out_valid`, `!chunk_tready`). These are derived from `slot` and `out_valid`; there is no separate state register.

## Timing
Reset:
- `sender_rstn` low at an edge clears everything: `slot`, `acc_*`, `out_valid`, `out_data` = 0, `out_last`, `misaligned_last`, `words_sent`.
- `pixel_tready` is forced 0 while `sender_rstn` is low.
- Reset mid-word discards partial pixels and any un-drained output word.

Throughput and latency:
- Throughput is 1 pixel per cycle, hence 1 word per 8 cycles, with `chunk_tready` held high and `chunk_prog_full` low.
- Latency: 8th pixel accepted at edge N → `chunk_tvalid` = 1 in the cycle after edge N.
- Back-to-back: a word drains at the same edge the next word loads, so `chunk_tvalid` stays 1 with no bubble.

Boundary conditions:
- `chunk_prog_full` blocks input at any slot. It does not affect the output handshake, so the output word still drains.
- `pixel_tvalid` low mid-word: the accumulator holds indefinitely.
- `words_sent` at 2^`COUNT_WIDTH`−1 plus one handshake → 0.

## Configuration
`PIXEL_STACKER_FLUSH_EN`:
- Defined: an accept with `pixel_tlast == 1` and `slot < 7` closes the word immediately.
  - Unfilled slots are zero-padded.
  - `out_last` = 1.
  - `slot` ← 0.
  - It obeys the same ready rule, with the `slot == 7` term widened to "closing accept".
  - `misaligned_last` still sets.
- Undefined: a mid-word `tlast` only latches `acc_last`. The word closes after its 8th pixel with `chunk_tlast` = 1.

## Test plan
- **Pack order:** reset, then pixels 0x0001..0x0008 on consecutive cycles with tready high → one word 0x0008_0007_0006_0005_0004_0003_0002_0001 the cycle after the 8th accept; `words_sent` = 1; `chunk_tlast` = 0.
- **Backpressure:** hold `chunk_tready` = 0 while sending 16 pixels → first word stable; `pixel_tready` drops at slot 7 of the second word; release tready → both words out in order, `words_sent` = 2, no pixels lost.
- **Prog-full throttle:** assert `chunk_prog_full` after pixel 3 for 5 cycles → `pixel_tready` = 0 for exactly those cycles; the word completes afterward with correct data.
- **Aligned frame end:** 16 pixels with `tlast` on the 16th → second word has `chunk_tlast` = 1; `misaligned_last` stays 0.
- **Misaligned tlast:** `tlast` on pixel 5.
  - Flush defined: word = pixels 1–5 in bits [79:0] and zeros above, `chunk_tlast` = 1, `misaligned_last` = 1.
  - Flush undefined: the word emits after pixel 8, with `chunk_tlast` = 1.
- **Reset mid-operation:** deassert reset after 3 pixels and an un-drained word → all outputs 0; the next 8 pixels form a clean word starting at slot 0.
